// File: rtl/switch_allocator_if.sv
// Bundle between the per-input route/FIFO side, the switch allocator and the crossbar.
// Latency: none; this is wiring only.
// Backpressure: out_ready carries downstream acceptance; in_read pops the input FIFOs.
interface switch_allocator_if;
    logic [24:0] req;         // req[5*i+o]: input i requests output o
    logic [4:0]  in_valid;    // input FIFO i non-empty
    logic [14:0] in_flit_id;  // head flit type of input i at [3*i+2:3*i]
    logic [4:0]  out_ready;   // output o can take a flit this cycle
    logic [4:0]  in_read;     // pop head flit of input i
    logic [4:0]  out_valid;   // flit present on output o
    logic [14:0] out_sel;     // crossbar select of output o, 3'd7 when idle
    logic [4:0]  out_busy;    // output o allocated to a packet

    // Routing/FIFO side drives requests and sees grants.
    modport master (
        output req, in_valid, in_flit_id, out_ready,
        input  in_read, out_valid, out_sel, out_busy
    );

    // Allocator side.
    modport slave (
        input  req, in_valid, in_flit_id, out_ready,
        output in_read, out_valid, out_sel, out_busy
    );
endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin allocator: grants on a HEADER, holds the output until the TAIL transfers.
// Latency: grant registered one cycle after an eligible header; pops/out_valid are combinational off the grant.
// Backpressure: out_ready or in_valid low stalls the owner's pop; the grant and owner are held indefinitely.
module switch_allocator (
    input  logic              clk,
    input  logic              rst,
    switch_allocator_if.slave bus
);
    localparam int         NPORT       = 5;
    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;
    localparam logic [2:0] NO_OWNER    = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } out_state_e;

    out_state_e state_q  [NPORT];
    out_state_e state_d  [NPORT];
    logic [2:0] owner_q  [NPORT];
    logic [2:0] owner_d  [NPORT];
    logic [2:0] rr_ptr_q [NPORT];
    logic [2:0] rr_ptr_d [NPORT];

    logic [4:0]       req_red  [NPORT];  // per input: lowest requested output only
    logic [NPORT-1:0] eligible [NPORT];  // eligible[o][i]
    logic [NPORT-1:0] owns_any;          // input i currently owns some output
    logic [NPORT-1:0] out_valid_c;
    logic [NPORT-1:0] in_read_c;

    logic       found;
    logic [3:0] scan_sum;
    logic [2:0] scan_idx;

    // Reduce each input's request to its lowest set bit (N > E > W > S > L).
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            req_red[i] = bus.req[5*i +: 5] & (~bus.req[5*i +: 5] + 5'd1);
        end
    end

    // Eligibility: valid HEADER at the head, requesting o, and not already holding an output.
    always_comb begin
        owns_any = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (state_q[o] == ST_BUSY && owner_q[o] == 3'(i)) begin
                    owns_any[i] = 1'b1;
                end
            end
        end
        for (int o = 0; o < NPORT; o++) begin
            eligible[o] = '0;
            for (int i = 0; i < NPORT; i++) begin
                eligible[o][i] = bus.in_valid[i]
                              && (bus.in_flit_id[3*i +: 3] == FLIT_HEADER)
                              && req_red[i][o]
                              && !owns_any[i];
            end
        end
    end

    // Flit transfer on busy outputs: owner has a flit and downstream accepts it.
    always_comb begin
        out_valid_c = '0;
        in_read_c   = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (state_q[o] == ST_BUSY && owner_q[o] == 3'(i)
                    && bus.in_valid[i] && bus.out_ready[o]) begin
                    out_valid_c[o] = 1'b1;
                    in_read_c[i]   = 1'b1;
                end
            end
        end
        if (rst) begin
            out_valid_c = '0;
            in_read_c   = '0;
        end
    end

    // Per-output next state: round-robin grant from IDLE, release on TAIL transfer.
    // A releasing output never re-grants in the same cycle.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int o = 0; o < NPORT; o++) begin
            case (state_q[o])
                ST_IDLE: begin
                    found = 1'b0;
                    for (int k = 0; k < NPORT; k++) begin
                        scan_sum = {1'b0, rr_ptr_q[o]} + 4'(k);
                        scan_idx = (scan_sum >= 4'd5) ? 3'(scan_sum - 4'd5) : scan_sum[2:0];
                        if (!found && eligible[o][scan_idx]) begin
                            found       = 1'b1;
                            state_d[o]  = ST_BUSY;
                            owner_d[o]  = scan_idx;
                        end
                    end
                end
                ST_BUSY: begin
                    for (int i = 0; i < NPORT; i++) begin
                        if (owner_q[o] == 3'(i) && out_valid_c[o]
                            && bus.in_flit_id[3*i +: 3] == FLIT_TAIL) begin
                            state_d[o]  = ST_IDLE;
                            owner_d[o]  = NO_OWNER;
                            rr_ptr_d[o] = (i == NPORT-1) ? 3'd0 : 3'(i + 1);
                        end
                    end
                end
                default: begin
                    state_d[o] = ST_IDLE;
                    owner_d[o] = NO_OWNER;
                end
            endcase
        end
    end

    // State registers; reset returns every output to idle with no owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NPORT; o++) begin
                state_q[o]  <= ST_IDLE;
                owner_q[o]  <= NO_OWNER;
                rr_ptr_q[o] <= 3'd0;
            end
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                state_q[o]  <= state_d[o];
                owner_q[o]  <= owner_d[o];
                rr_ptr_q[o] <= rr_ptr_d[o];
            end
        end
    end

    // Registered crossbar selects and busy flags straight from the owner/state flops.
    always_comb begin
        bus.out_sel  = '1;
        bus.out_busy = '0;
        for (int o = 0; o < NPORT; o++) begin
            bus.out_sel[3*o +: 3] = owner_q[o];
            bus.out_busy[o]       = (state_q[o] == ST_BUSY);
        end
    end

    assign bus.in_read   = in_read_c;
    assign bus.out_valid = out_valid_c;

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus randomized traffic against a packet-level model.
// Latency: inputs applied on negedge, outputs sampled 1ns later, state advances on posedge.
// Backpressure: driven through per-input valid enables and per-output ready.
module tb_switch_allocator;
    localparam logic [2:0] HDR = 3'b001;
    localparam logic [2:0] PAY = 3'b010;
    localparam logic [2:0] TL  = 3'b100;
    localparam int         QD  = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;

    switch_allocator_if bus ();
    switch_allocator dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Input FIFO contents: flit type and the route request carried with it.
    logic [2:0] fq_flit [5][QD];
    logic [4:0] fq_req  [5][QD];
    int         q_head  [5];
    int         q_tail  [5];
    logic [4:0] vld_en;
    logic [4:0] ready_drv;
    bit         junk_mode;
    logic [4:0] cur_vld;
    logic [2:0] cur_flit [5];
    logic [4:0] cur_req  [5];

    // Reference model: per-output busy/owner/round-robin start point.
    bit         m_busy  [5];
    int         m_owner [5];
    int         m_rr    [5];
    logic [4:0]  e_rd, e_ov, e_busy;
    logic [14:0] e_sel;

    task automatic push_pkt(int i, logic [4:0] route, int npay);
        fq_flit[i][q_tail[i]] = HDR; fq_req[i][q_tail[i]] = route; q_tail[i]++;
        for (int p = 0; p < npay; p++) begin
            fq_flit[i][q_tail[i]] = PAY; fq_req[i][q_tail[i]] = route; q_tail[i]++;
        end
        fq_flit[i][q_tail[i]] = TL; fq_req[i][q_tail[i]] = route; q_tail[i]++;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < 5; i++) begin
            if (q_head[i] < q_tail[i] && vld_en[i]) begin
                cur_vld[i]  = 1'b1;
                cur_flit[i] = fq_flit[i][q_head[i]];
                cur_req[i]  = fq_req[i][q_head[i]];
            end else begin
                cur_vld[i]  = 1'b0;
                cur_flit[i] = junk_mode ? 3'($urandom) : 3'b000;
                cur_req[i]  = junk_mode ? 5'($urandom) : 5'b00000;
            end
            bus.in_valid[i]          = cur_vld[i];
            bus.in_flit_id[3*i +: 3] = cur_flit[i];
            bus.req[5*i +: 5]        = cur_req[i];
        end
        bus.out_ready = ready_drv;
    endtask

    // Advance one clock; pop the FIFOs named in 'pop' at the edge.
    task automatic step(logic [4:0] pop);
        @(posedge clk);
        for (int i = 0; i < 5; i++) if (pop[i] && q_head[i] < q_tail[i]) q_head[i]++;
        @(negedge clk);
        apply_inputs();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin q_head[i] = 0; q_tail[i] = 0; end
        vld_en = '1; ready_drv = '1; junk_mode = 1'b0;
        apply_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply_inputs();
        #1;
    endtask

    function automatic int lowest_set(logic [4:0] v);
        for (int b = 0; b < 5; b++) if (v[b]) return b;
        return -1;
    endfunction

    task automatic model_expect();
        e_rd = '0; e_ov = '0; e_busy = '0; e_sel = '1;
        for (int o = 0; o < 5; o++) begin
            if (m_busy[o]) begin
                e_busy[o] = 1'b1;
                e_sel[3*o +: 3] = 3'(m_owner[o]);
                if (cur_vld[m_owner[o]] && ready_drv[o]) begin
                    e_ov[o] = 1'b1;
                    e_rd[m_owner[o]] = 1'b1;
                end
            end
        end
    endtask

    // Packet-level rules: release on a delivered TAIL; otherwise grant the eligible
    // input closest (cyclically) at or after the pointer.
    task automatic model_advance();
        bit nb [5]; int no [5]; int nr [5]; bit held [5];
        int best, bestd, d;
        for (int i = 0; i < 5; i++) held[i] = 1'b0;
        for (int o = 0; o < 5; o++) if (m_busy[o]) held[m_owner[o]] = 1'b1;
        for (int o = 0; o < 5; o++) begin
            nb[o] = m_busy[o]; no[o] = m_owner[o]; nr[o] = m_rr[o];
            if (m_busy[o]) begin
                if (e_ov[o] && cur_flit[m_owner[o]] == TL) begin
                    nb[o] = 1'b0; no[o] = 7; nr[o] = (m_owner[o] + 1) % 5;
                end
            end else begin
                best = -1; bestd = 5;
                for (int i = 0; i < 5; i++) begin
                    d = (i - m_rr[o] + 5) % 5;
                    if (cur_vld[i] && cur_flit[i] == HDR && !held[i]
                        && lowest_set(cur_req[i]) == o && d < bestd) begin
                        best = i; bestd = d;
                    end
                end
                if (best >= 0) begin nb[o] = 1'b1; no[o] = best; end
            end
        end
        for (int o = 0; o < 5; o++) begin m_busy[o] = nb[o]; m_owner[o] = no[o]; m_rr[o] = nr[o]; end
    endtask

    task automatic test_reset();
        vld_en = '1; ready_drv = '1; junk_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin q_head[i] = 0; q_tail[i] = 0; end
        apply_inputs();
        #1 rst = 1'b1;
        #1;
        vectors++; if (bus.out_busy !== 5'h00) begin miscompares++; $display("FAIL reset_busy: got %h expected 00", bus.out_busy); end
        vectors++; if (bus.out_sel !== 15'h7FFF) begin miscompares++; $display("FAIL reset_sel: got %h expected 7fff", bus.out_sel); end
        vectors++; if (bus.in_read !== 5'h00) begin miscompares++; $display("FAIL reset_in_read: got %h expected 00", bus.in_read); end
        do_reset();
        // Move the S pointer off zero with one packet from input 0.
        push_pkt(0, 5'b01000, 0); apply_inputs(); #1;
        repeat (3) step(bus.in_read);
        vectors++; if (bus.out_busy !== 5'h00) begin miscompares++; $display("FAIL pre_reset_release: got %h expected 00", bus.out_busy); end
        // Partial packet on W, then asynchronous reset between clock edges.
        push_pkt(1, 5'b00100, 3); apply_inputs(); #1;
        step(bus.in_read); step(bus.in_read);
        vectors++; if (bus.out_busy[2] !== 1'b1) begin miscompares++; $display("FAIL midpkt_busy: got %b expected 1", bus.out_busy[2]); end
        #1 rst = 1'b1;
        #1;
        vectors++; if (bus.out_busy !== 5'h00) begin miscompares++; $display("FAIL async_busy: got %h expected 00", bus.out_busy); end
        vectors++; if (bus.out_sel !== 15'h7FFF) begin miscompares++; $display("FAIL async_sel: got %h expected 7fff", bus.out_sel); end
        vectors++; if (bus.in_read !== 5'h00) begin miscompares++; $display("FAIL async_in_read: got %h expected 00", bus.in_read); end
        vectors++; if (bus.out_valid !== 5'h00) begin miscompares++; $display("FAIL async_out_valid: got %h expected 00", bus.out_valid); end
        do_reset();
        // Pointer back at 0: input 0 beats input 2 for S.
        push_pkt(2, 5'b01000, 0); push_pkt(0, 5'b01000, 0); apply_inputs(); #1;
        step(bus.in_read);
        vectors++; if (bus.out_sel[11:9] !== 3'd0) begin miscompares++; $display("FAIL rr_after_reset: got %0d expected 0", bus.out_sel[11:9]); end
    endtask

    task automatic test_single_packet();
        int n_reads;
        do_reset();
        push_pkt(4, 5'b00010, 1); apply_inputs(); #1;
        vectors++; if (bus.in_read !== 5'h00) begin miscompares++; $display("FAIL sp_no_pop_at_grant: got %b expected 00000", bus.in_read); end
        step(bus.in_read);
        vectors++; if (bus.out_sel[5:3] !== 3'd4) begin miscompares++; $display("FAIL sp_sel_e: got %0d expected 4", bus.out_sel[5:3]); end
        vectors++; if (bus.out_busy !== 5'b00010) begin miscompares++; $display("FAIL sp_busy: got %b expected 00010", bus.out_busy); end
        vectors++; if (bus.out_valid !== 5'b00010) begin miscompares++; $display("FAIL sp_out_valid: got %b expected 00010", bus.out_valid); end
        n_reads = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.in_read === 5'b10000) n_reads++;
            step(bus.in_read);
        end
        vectors++; if (n_reads != 3) begin miscompares++; $display("FAIL sp_read_run: got %0d expected 3", n_reads); end
        vectors++; if (bus.out_busy !== 5'h00) begin miscompares++; $display("FAIL sp_release_busy: got %b expected 00000", bus.out_busy); end
        vectors++; if (bus.out_sel !== 15'h7FFF) begin miscompares++; $display("FAIL sp_release_sel: got %h expected 7fff", bus.out_sel); end
    endtask

    task automatic test_round_robin();
        int exp_seq [6] = '{0, 2, 3, 0, 2, 3};
        int got [6];
        int n;
        logic prev;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_pkt(0, 5'b01000, 0); push_pkt(2, 5'b01000, 0); push_pkt(3, 5'b01000, 0);
        end
        apply_inputs(); #1;
        n = 0; prev = 1'b0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            if (bus.out_busy[3] && !prev) begin got[n] = int'(bus.out_sel[11:9]); n++; end
            prev = bus.out_busy[3];
            step(bus.in_read);
        end
        vectors++; if (n != 6) begin miscompares++; $display("FAIL rr_grant_count: got %0d expected 6", n); end
        for (int k = 0; k < n; k++) begin
            vectors++; if (got[k] != exp_seq[k]) begin miscompares++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, got[k], exp_seq[k]); end
        end
    endtask

    task automatic test_backpressure();
        int cnt;
        do_reset();
        push_pkt(1, 5'b00100, 3); apply_inputs(); #1;
        step(bus.in_read);
        vectors++; if (bus.out_sel[8:6] !== 3'd1) begin miscompares++; $display("FAIL bp_grant: got %0d expected 1", bus.out_sel[8:6]); end
        vectors++; if (bus.in_read !== 5'b00010) begin miscompares++; $display("FAIL bp_header_pop: got %b expected 00010", bus.in_read); end
        ready_drv[2] = 1'b0;
        step(bus.in_read);
        for (int k = 0; k < 4; k++) begin
            vectors++; if (bus.in_read !== 5'h00) begin miscompares++; $display("FAIL bp_stall_pop[%0d]: got %b expected 00000", k, bus.in_read); end
            vectors++; if (bus.out_sel[8:6] !== 3'd1 || bus.out_busy[2] !== 1'b1) begin
                miscompares++; $display("FAIL bp_stall_hold[%0d]: got sel %0d busy %b expected sel 1 busy 1", k, bus.out_sel[8:6], bus.out_busy[2]);
            end
            if (k == 3) ready_drv[2] = 1'b1;
            step(bus.in_read);
        end
        vectors++; if (bus.in_read !== 5'b00010) begin miscompares++; $display("FAIL bp_resume: got %b expected 00010", bus.in_read); end
        vld_en[1] = 1'b0;
        step(bus.in_read);
        vectors++; if (bus.in_read !== 5'h00 || bus.out_busy[2] !== 1'b1) begin
            miscompares++; $display("FAIL bp_empty_stall: got read %b busy %b expected 00000 1", bus.in_read, bus.out_busy[2]);
        end
        vld_en[1] = 1'b1;
        step(bus.in_read);
        cnt = 0;
        for (int c = 0; c < 20 && bus.out_busy[2]; c++) begin
            if (bus.in_read[1]) cnt++;
            step(bus.in_read);
        end
        vectors++; if (cnt != 3) begin miscompares++; $display("FAIL bp_remaining_pops: got %0d expected 3", cnt); end
    endtask

    task automatic test_multibit_request();
        do_reset();
        push_pkt(1, 5'b01010, 0); apply_inputs(); #1;
        step(bus.in_read);
        vectors++; if (bus.out_busy !== 5'b00010) begin miscompares++; $display("FAIL mb_busy: got %b expected 00010", bus.out_busy); end
        vectors++; if (bus.out_sel[5:3] !== 3'd1) begin miscompares++; $display("FAIL mb_sel_e: got %0d expected 1", bus.out_sel[5:3]); end
        vectors++; if (bus.out_sel[11:9] !== 3'd7) begin miscompares++; $display("FAIL mb_sel_s: got %0d expected 7", bus.out_sel[11:9]); end
    endtask

    task automatic test_contention();
        do_reset();
        push_pkt(0, 5'b10000, 1); push_pkt(3, 5'b10000, 0); push_pkt(2, 5'b00001, 0);
        apply_inputs(); #1;
        step(bus.in_read);
        vectors++; if (bus.out_busy !== 5'b10001) begin miscompares++; $display("FAIL ct_busy: got %b expected 10001", bus.out_busy); end
        vectors++; if (bus.out_sel[14:12] !== 3'd0 || bus.out_sel[2:0] !== 3'd2) begin
            miscompares++; $display("FAIL ct_sel: got L %0d N %0d expected L 0 N 2", bus.out_sel[14:12], bus.out_sel[2:0]);
        end
        vectors++; if (bus.in_read !== 5'b00101) begin miscompares++; $display("FAIL ct_pops: got %b expected 00101", bus.in_read); end
        step(bus.in_read); step(bus.in_read);
        vectors++; if (bus.out_busy !== 5'b10000) begin miscompares++; $display("FAIL ct_n_released: got %b expected 10000", bus.out_busy); end
        step(bus.in_read);
        vectors++; if (bus.out_busy[4] !== 1'b0) begin miscompares++; $display("FAIL ct_release_only: got %b expected 0", bus.out_busy[4]); end
        step(bus.in_read);
        vectors++; if (bus.out_busy[4] !== 1'b1 || bus.out_sel[14:12] !== 3'd3) begin
            miscompares++; $display("FAIL ct_second_grant: got busy %b sel %0d expected 1 3", bus.out_busy[4], bus.out_sel[14:12]);
        end
    endtask

    task automatic test_non_header();
        do_reset();
        fq_flit[2][0] = PAY; fq_req[2][0] = 5'b00010; q_tail[2] = 1;
        apply_inputs(); #1;
        for (int k = 0; k < 3; k++) begin
            vectors++; if (bus.out_busy !== 5'h00 || bus.in_read !== 5'h00) begin
                miscompares++; $display("FAIL nh_ignored[%0d]: got busy %b read %b expected 00000 00000", k, bus.out_busy, bus.in_read);
            end
            step(bus.in_read);
        end
    endtask

    task automatic test_random_traffic();
        bit drained;
        do_reset();
        junk_mode = 1'b1;
        for (int o = 0; o < 5; o++) begin m_busy[o] = 1'b0; m_owner[o] = 7; m_rr[o] = 0; end
        for (int i = 0; i < 5; i++) begin
            int npk;
            npk = $urandom_range(3, 6);
            for (int p = 0; p < npk; p++) push_pkt(i, 5'($urandom_range(1, 31)), $urandom_range(0, 3));
        end
        apply_inputs(); #1;
        drained = 1'b0;
        for (int c = 0; c < 3000 && !drained; c++) begin
            model_expect();
            vectors++; if (bus.in_read !== e_rd) begin miscompares++; $display("FAIL rand_in_read cyc %0d: got %b expected %b", c, bus.in_read, e_rd); end
            vectors++; if (bus.out_valid !== e_ov) begin miscompares++; $display("FAIL rand_out_valid cyc %0d: got %b expected %b", c, bus.out_valid, e_ov); end
            vectors++; if (bus.out_sel !== e_sel) begin miscompares++; $display("FAIL rand_out_sel cyc %0d: got %h expected %h", c, bus.out_sel, e_sel); end
            vectors++; if (bus.out_busy !== e_busy) begin miscompares++; $display("FAIL rand_out_busy cyc %0d: got %b expected %b", c, bus.out_busy, e_busy); end
            model_advance();
            for (int i = 0; i < 5; i++) vld_en[i] = ($urandom_range(0, 99) < 85);
            for (int o = 0; o < 5; o++) ready_drv[o] = ($urandom_range(0, 99) < 75);
            step(e_rd);
            drained = 1'b1;
            for (int i = 0; i < 5; i++) if (q_head[i] != q_tail[i] || m_busy[i]) drained = 1'b0;
        end
        vectors++; if (!drained) begin miscompares++; $display("FAIL rand_drain: got not drained expected all packets delivered"); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_multibit_request();
        test_contention();
        test_non_header();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-router output-port allocator that sits between the five per-input LBDR route-computation units and the crossbar. It arbitrates each output port among inputs whose HEADER flit requests it, using round-robin. It holds the grant for the whole packet, through the TAIL flit, and generates the input-FIFO read strobes and crossbar select lines. One instance per router.

## Interface
- NPORT, 5, number of ports; fixed at 5, other values unsupported. Port index order everywhere: 0=N, 1=E, 2=W, 3=S, 4=L.
- clk  input  1  router clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  25  route request; req[5*i+o] = input i's LBDR result requests output o (bit order Nport, Eport, Wport, Sport, Lport).
- in_valid  input  5  input FIFO i non-empty (~empty).
- in_flit_id  input  15  flit_id of head flit of input i, bits [3*i+2:3*i]; codes from the shared parameters include: `HEADER=3'b001, `PAYLOAD=3'b010, `TAIL=3'b100.
- out_ready  input  5  downstream of output o can accept a flit this cycle.
- in_read  output  5  pop head flit of input i (combinational).
- out_valid  output  5  flit on output o this cycle (combinational).
- out_sel  output  15  crossbar select for output o, bits [3*o+2:3*o]: owning input index, 3'd7 when idle (registered).
- out_busy  output  5  output o is allocated to a packet (registered).

## Operation
- Per-output state: IDLE or BUSY, owner[2:0], rr_ptr[2:0] (range 0..4).
- Request reduction: if an input's req slice has several bits set, only the lowest-index bit is honoured (N>E>W>S>L). All-zero means no request.
- Eligible(i,o): in_valid[i] && head flit is `HEADER && reduced req of i selects o && input i is not the owner of any BUSY output.
- IDLE -> BUSY: pick the first eligible i scanning rr_ptr[o], rr_ptr[o]+1, ... mod 5. Register owner[o]=i and out_sel[o]=i, then go BUSY. The header is not popped in the grant cycle.
- BUSY transfer: out_valid[o] = in_valid[owner] && out_ready[o]. in_read[owner] = out_valid[o].
- BUSY -> IDLE: when a transfer occurs and the head flit is `TAIL. Next cycle: rr_ptr[o] = (owner+1) mod 5, out_sel[o]=3'd7, out_busy[o]=0.
- Because each input's request is one-hot after reduction, no input can be granted two outputs in the same cycle.
- An output that goes IDLE does not re-grant in the same cycle; the earliest new grant is the cycle after release.
- in_read is the OR over outputs of the per-output read strobes.

## Timing
- Reset (async assert, sync to clk on deassert): all outputs IDLE, owner=3'd7, rr_ptr=0, out_sel=15'h7FFF, out_busy=0. in_read=0 and out_valid=0 while rst is high.
- Latency: header eligible at edge t -> out_busy/out_sel updated at t+1 -> header popped at cycle t+1 if in_valid and out_ready.
- Throughput: 1 flit/cycle per output while in_valid && out_ready.
- Stalls: in_valid=0 (FIFO empty) or out_ready=0 mid-packet -> no pop, grant held indefinitely, owner unchanged.
- rst asserted mid-packet: immediate return to reset state; partial packet state discarded.
- Simultaneous events: release of output o and a new eligible header for o in the same cycle -> release only. Release by input i on output o and a new header of input i requesting output p in the same cycle -> i is not eligible for p until the next cycle.
- Non-HEADER head flit at an IDLE output: ignored, never granted.

## Test plan
- Reset: assert rst mid-simulation without clk edge -> out_busy=0, out_sel=15'h7FFF, in_read=0 immediately. After release, rr_ptr of all outputs = 0.
- Single packet: input 4 (L) sends HEADER requesting E (req[21]=1), then PAYLOAD, then TAIL, out_ready=5'h1F -> out_sel[5:3]=3'd4 one cycle after request. in_read[4] high for 3 consecutive cycles. out_busy[1] clears the cycle after TAIL.
- Round-robin: inputs 0, 2, 3 all hold HEADERs to S continuously with 2-flit packets -> S granted in order 0, 2, 3, 0. rr_ptr after the first release = 1.
- Backpressure: during a BUSY packet on W, drop out_ready[2] for 4 cycles -> in_read of the owner = 0 for those cycles, owner and out_sel unchanged, transfer resumes after.
- Multi-bit request: input 1 req slice = 5'b01010 (E and S) -> only E (bit 1) allocated, S remains IDLE.
- Concurrency/contention: input 0 to L and input 3 to L together while input 2 to N -> N and L granted in the same cycle, L grant to input 0 (rr_ptr=0), input 3 served after input 0's TAIL.
